pipeline_forwarding_unit: RTL and testbench
===========================================

Name: pipeline_forwarding_unit

Overview:
- Parametrised successor to the stage-3 forwarding logic. Resolves RAW hazards for NUM_SRC execute-stage source operands against NUM_STG younger-to-older downstream stages.
- Selects forwarded data with youngest-wins priority and raises a load-use/not-ready stall.
- Tracks out-of-pipeline long-latency writers (divider, non-blocking load return) in a register scoreboard.
- Holds a one-entry retire buffer that covers the write-then-read gap of a non-write-through register file. Sits beside execute; outputs feed the execute operand muxes and the hazard unit.

Parameters:
- NUM_STG, 2, downstream stages able to forward; index 0 is the stage immediately after execute, index NUM_STG-1 is writeback.
- NUM_SRC, 2, source operands checked in execute.
- WORD_W, 32, data width.
- REG_AW, 5, register address width.
- RETIRE_BUF, 1, 1 enables the retire buffer.
- CNT_W, 16, stall counter width.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- rs_e  in  NUM_SRC*REG_AW  execute source register numbers
- rs_used_e  in  NUM_SRC  operand actually read this cycle
- stg_valid  in  NUM_STG  stage holds a live instruction
- stg_reg_write  in  NUM_STG  stage instruction writes rd
- stg_rd  in  NUM_STG*REG_AW  stage destination register
- stg_ready  in  NUM_STG  stage result available (0 for a load before data return)
- stg_data  in  NUM_STG*WORD_W  stage result
- sb_set  in  1  issue of a long-latency op this cycle
- sb_set_rd  in  REG_AW  its destination
- sb_clr  in  1  long-latency result written to register file this cycle
- sb_clr_rd  in  REG_AW  its destination
- fwd_en  out  NUM_SRC  operand replaced by forwarded data
- fwd_data  out  NUM_SRC*WORD_W  forwarded value (0 when fwd_en=0)
- stall_e  out  1  hold execute and earlier stages
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Match for source s at stage i: rs_used_e[s] & stg_valid[i] & stg_reg_write[i] & stg_rd[i]==rs_e[s] & rs_e[s]!=0.
- Priority: lowest matching i wins. The retire buffer ranks below every stage. Register file is the default (fwd_en=0).
- Winner stage not ready: stall_e=1, fwd_en[s]=0. An older ready match never masks a younger unready one.
- Scoreboard: REG_AW-bit-indexed pending vector, bit 0 hardwired 0.
  - rs_used_e[s] & pending[rs_e[s]] -> stall_e=1, unless a stage match already forwards that register.
  - sb_set sets, sb_clr clears; both take effect next cycle.
  - Same register set and cleared in one cycle -> set wins (new issue supersedes old completion).
  - sb_set of x0 is ignored.
  - sb_clr of a non-pending register is a no-op.
- Retire buffer (RETIRE_BUF=1):
  - Capture condition: stage NUM_STG-1 valid & reg_write & rd!=0.
  - On capture, next cycle holds {rd,data} with buf_valid=1; otherwise buf_valid=0 next cycle (one-cycle lifetime).
  - A buf_valid match forwards buffer data.
  - RETIRE_BUF=0 -> buffer logic absent, never matches.
- stall_e and fwd outputs are combinational from inputs plus registered state. Zero-cycle forward latency.
- stall_cnt increments each cycle stall_e=1 and saturates at all-ones.
- Reset (any time, asynchronous): pending=0, buf_valid=0, stall_cnt=0. Outputs then follow inputs only. stall_e=0 and fwd_en=0 when all stg_valid=0.

Decomposition:
- Shared package rv32i_types_pkg: word_t, reg_addr_t, and a new fwd_src_e enum (FWD_RF, FWD_STG, FWD_BUF) for debug visibility.
- Natural sub-module: fwd_scoreboard (pending vector, set/clear, lookup ports per source). Priority select stays in the top.

Test Plan:
- Stage0 rd=5 ready data=0xAAAA_0001, stage1 rd=5 data=0xBBBB_0002, rs_e[0]=5 -> fwd_en[0]=1, fwd_data[0]=0xAAAA_0001, stall_e=0.
- Stage0 load rd=7 stg_ready=0, rs_e[1]=7 -> stall_e=1, fwd_en[1]=0. Next cycle stg_ready=1, data=0x1234 -> fwd_data[1]=0x1234, stall_e=0. stall_cnt=1.
- rs_e=0 with stage0 rd=0 reg_write=1 -> fwd_en=0, stall_e=0.
- sb_set rd=9, then rs_e[0]=9 -> stall_e=1 each cycle until sb_clr rd=9. Clearing cycle +1 -> stall_e=0. Same-cycle sb_set/sb_clr rd=9 -> stays pending.
- Writeback stage rd=3 data=0xDEAD_BEEF, next cycle no stage matches, rs_e[0]=3 -> fwd_data[0]=0xDEAD_BEEF for exactly one cycle, fwd_en=0 the cycle after.
- Pending rd=4 and stall_cnt=10, assert RST mid-cycle -> pending cleared, stall_cnt=0 immediately, rs_e=4 no stall.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I pipeline types: data/register widths and the forwarding-source tag.
package rv32i_types_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_NUM = 32;

  typedef logic [XLEN-1:0]          word_t;
  typedef logic [$clog2(REG_NUM)-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_STG = 2'd1,
    FWD_BUF = 2'd2
  } fwd_src_e;

endpackage

// File: rtl/pipeline_forwarding_unit_if.sv
// Execute-side forwarding bus: operand/stage hazard inputs and forward/stall results.
interface pipeline_forwarding_unit_if #(
  parameter int unsigned NUM_STG = 2,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CNT_W   = 16
);
  logic [NUM_SRC*REG_AW-1:0] rs_e;
  logic [NUM_SRC-1:0]        rs_used_e;
  logic [NUM_STG-1:0]        stg_valid;
  logic [NUM_STG-1:0]        stg_reg_write;
  logic [NUM_STG*REG_AW-1:0] stg_rd;
  logic [NUM_STG-1:0]        stg_ready;
  logic [NUM_STG*WORD_W-1:0] stg_data;
  logic                      sb_set;
  logic [REG_AW-1:0]         sb_set_rd;
  logic                      sb_clr;
  logic [REG_AW-1:0]         sb_clr_rd;
  logic [NUM_SRC-1:0]        fwd_en;
  logic [NUM_SRC*WORD_W-1:0] fwd_data;
  logic                      stall_e;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output rs_e, rs_used_e, stg_valid, stg_reg_write, stg_rd, stg_ready, stg_data,
           sb_set, sb_set_rd, sb_clr, sb_clr_rd,
    input  fwd_en, fwd_data, stall_e, stall_cnt
  );

  modport slave (
    input  rs_e, rs_used_e, stg_valid, stg_reg_write, stg_rd, stg_ready, stg_data,
           sb_set, sb_set_rd, sb_clr, sb_clr_rd,
    output fwd_en, fwd_data, stall_e, stall_cnt
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Pending-writer scoreboard for long-latency ops; one lookup port per source operand.
module fwd_scoreboard #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      set_i,
  input  logic [REG_AW-1:0]         set_rd_i,
  input  logic                      clr_i,
  input  logic [REG_AW-1:0]         clr_rd_i,
  input  logic [NUM_SRC*REG_AW-1:0] lookup_rd_i,
  output logic [NUM_SRC-1:0]        pending_o
);
  localparam int unsigned NREG = 1 << REG_AW;

  logic [NREG-1:0] pending_q, pending_d;

  // Clear is applied before set so a same-cycle re-issue stays pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_i) pending_d[clr_rd_i] = 1'b0;
    if (set_i) pending_d[set_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  always_comb begin
    pending_o = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++)
      pending_o[s] = pending_q[lookup_rd_i[s*REG_AW +: REG_AW]];
  end
endmodule

// File: rtl/pipeline_forwarding_unit.sv
// RAW-hazard forwarding for execute operands: youngest-stage priority, retire buffer, scoreboard stall.
module pipeline_forwarding_unit
  import rv32i_types_pkg::*;
#(
  parameter int unsigned NUM_STG    = 2,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned RETIRE_BUF = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  pipeline_forwarding_unit_if.slave bus
);
  localparam int unsigned WB = NUM_STG - 1;

  logic [NUM_SRC-1:0]        pending;
  logic                      buf_valid_q;
  logic [REG_AW-1:0]         buf_rd_q;
  logic [WORD_W-1:0]         buf_data_q;
  logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;
  logic                      stall;
  logic [NUM_SRC-1:0]        fwd_en;
  logic [NUM_SRC*WORD_W-1:0] fwd_data;
  fwd_src_e                  fwd_src [NUM_SRC];
  logic [REG_AW-1:0]         rs_s;
  logic [WORD_W-1:0]         data_s;
  logic                      live_s, hit_s, unready_s;
  int unsigned               win_s;

  fwd_scoreboard #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) u_sb (
    .clk_i       (CLK),
    .rst_i       (RST),
    .set_i       (bus.sb_set),
    .set_rd_i    (bus.sb_set_rd),
    .clr_i       (bus.sb_clr),
    .clr_rd_i    (bus.sb_clr_rd),
    .lookup_rd_i (bus.rs_e),
    .pending_o   (pending)
  );

  if (RETIRE_BUF != 0) begin : g_rbuf
    logic cap;
    assign cap = bus.stg_valid[WB] && bus.stg_reg_write[WB] &&
                 (bus.stg_rd[WB*REG_AW +: REG_AW] != '0);

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        buf_valid_q <= 1'b0;
        buf_rd_q    <= '0;
        buf_data_q  <= '0;
      end else begin
        buf_valid_q <= cap;
        if (cap) begin
          buf_rd_q   <= bus.stg_rd[WB*REG_AW +: REG_AW];
          buf_data_q <= bus.stg_data[WB*WORD_W +: WORD_W];
        end
      end
    end
  end else begin : g_no_rbuf
    assign buf_valid_q = 1'b0;
    assign buf_rd_q    = '0;
    assign buf_data_q  = '0;
  end

  // Buffer hit is taken first and then overridden by the youngest stage match,
  // so an unready young stage suppresses both older stages and the buffer.
  always_comb begin
    stall    = 1'b0;
    fwd_en   = '0;
    fwd_data = '0;
    rs_s      = '0;
    data_s    = '0;
    live_s    = 1'b0;
    hit_s     = 1'b0;
    unready_s = 1'b0;
    win_s     = 0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      rs_s       = bus.rs_e[s*REG_AW +: REG_AW];
      live_s     = bus.rs_used_e[s] && (rs_s != '0);
      data_s     = '0;
      hit_s      = 1'b0;
      unready_s  = 1'b0;
      win_s      = 0;
      fwd_src[s] = FWD_RF;
      if (live_s && buf_valid_q && (buf_rd_q == rs_s)) begin
        fwd_src[s] = FWD_BUF;
        data_s     = buf_data_q;
      end
      for (int unsigned i = 0; i < NUM_STG; i++) begin
        if (!hit_s && live_s && bus.stg_valid[i] && bus.stg_reg_write[i] &&
            (bus.stg_rd[i*REG_AW +: REG_AW] == rs_s)) begin
          hit_s = 1'b1;
          win_s = i;
        end
      end
      if (hit_s) begin
        if (bus.stg_ready[win_s]) begin
          fwd_src[s] = FWD_STG;
          data_s     = bus.stg_data[win_s*WORD_W +: WORD_W];
        end else begin
          fwd_src[s] = FWD_RF;
          data_s     = '0;
          unready_s  = 1'b1;
        end
      end
      stall = stall || unready_s || (bus.rs_used_e[s] && pending[s] && !hit_s);
      fwd_en[s] = (fwd_src[s] != FWD_RF);
      fwd_data[s*WORD_W +: WORD_W] = data_s;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign bus.fwd_en    = fwd_en;
  assign bus.fwd_data  = fwd_data;
  assign bus.stall_e   = stall;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_forwarding_unit.sv
// Directed bench: expected forward/stall results queued at drive time, popped and checked mid-cycle.
module tb_pipeline_forwarding_unit;
  logic clk;
  logic rst;

  typedef struct {
    string       tag;
    logic [1:0]  en;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        st;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] exp_cnt;
  int         tests;
  int         fails;

  pipeline_forwarding_unit_if #(
    .NUM_STG(2), .NUM_SRC(2), .WORD_W(32), .REG_AW(5), .CNT_W(4)
  ) bus ();

  pipeline_forwarding_unit #(
    .NUM_STG(2), .NUM_SRC(2), .WORD_W(32), .REG_AW(5), .RETIRE_BUF(1), .CNT_W(4)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clr_inputs();
    bus.rs_e          = '0;
    bus.rs_used_e     = '0;
    bus.stg_valid     = '0;
    bus.stg_reg_write = '0;
    bus.stg_rd        = '0;
    bus.stg_ready     = '0;
    bus.stg_data      = '0;
    bus.sb_set        = 1'b0;
    bus.sb_set_rd     = '0;
    bus.sb_clr        = 1'b0;
    bus.sb_clr_rd     = '0;
  endtask

  task automatic set_stg(input int i, input logic wr, input logic [4:0] rd,
                         input logic rdy, input logic [31:0] d);
    bus.stg_valid[i]          = 1'b1;
    bus.stg_reg_write[i]      = wr;
    bus.stg_rd[i*5 +: 5]      = rd;
    bus.stg_ready[i]          = rdy;
    bus.stg_data[i*32 +: 32]  = d;
  endtask

  task automatic set_rs(input int s, input logic [4:0] rd, input logic used);
    bus.rs_e[s*5 +: 5] = rd;
    bus.rs_used_e[s]   = used;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] en,
                            input logic [31:0] d0, input logic [31:0] d1, input logic st);
    exp_t e;
    e.tag = tag; e.en = en; e.d0 = d0; e.d1 = d1; e.st = st;
    exp_q.push_back(e);
  endtask

  task automatic check_cycle();
    exp_t e;
    @(negedge clk);
    e = exp_q.pop_front();
    tests++;
    assert (bus.fwd_en === e.en) else begin
      fails++; $error("FAIL %s fwd_en got %b expected %b", e.tag, bus.fwd_en, e.en);
    end
    tests++;
    assert (bus.fwd_data[31:0] === e.d0) else begin
      fails++; $error("FAIL %s fwd_data0 got %h expected %h", e.tag, bus.fwd_data[31:0], e.d0);
    end
    tests++;
    assert (bus.fwd_data[63:32] === e.d1) else begin
      fails++; $error("FAIL %s fwd_data1 got %h expected %h", e.tag, bus.fwd_data[63:32], e.d1);
    end
    tests++;
    assert (bus.stall_e === e.st) else begin
      fails++; $error("FAIL %s stall_e got %b expected %b", e.tag, bus.stall_e, e.st);
    end
    tests++;
    assert (bus.stall_cnt === exp_cnt) else begin
      fails++; $error("FAIL %s stall_cnt got %0d expected %0d", e.tag, bus.stall_cnt, exp_cnt);
    end
    if (!rst && e.st && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    exp_cnt = '0;
    rst     = 1'b1;
    clr_inputs();
    @(posedge clk); #1;
    expect_out("reset", 2'b00, 32'h0, 32'h0, 1'b0);
    check_cycle();
    rst = 1'b0;

    // youngest stage wins over writeback
    clr_inputs();
    set_stg(0, 1'b1, 5'd5, 1'b1, 32'hAAAA_0001);
    set_stg(1, 1'b1, 5'd5, 1'b1, 32'hBBBB_0002);
    set_rs(0, 5'd5, 1'b1);
    expect_out("fwd_young", 2'b01, 32'hAAAA_0001, 32'h0, 1'b0);
    check_cycle();

    clr_inputs();
    set_stg(0, 1'b1, 5'd7, 1'b0, 32'h0);
    set_rs(1, 5'd7, 1'b1);
    expect_out("load_wait", 2'b00, 32'h0, 32'h0, 1'b1);
    check_cycle();

    set_stg(0, 1'b1, 5'd7, 1'b1, 32'h0000_1234);
    expect_out("load_ready", 2'b10, 32'h0, 32'h0000_1234, 1'b0);
    check_cycle();

    clr_inputs();
    set_stg(0, 1'b1, 5'd0, 1'b1, 32'h55);
    set_rs(0, 5'd0, 1'b1);
    set_rs(1, 5'd0, 1'b1);
    expect_out("x0_never", 2'b00, 32'h0, 32'h0, 1'b0);
    check_cycle();

    clr_inputs();
    set_stg(0, 1'b1, 5'd5, 1'b1, 32'h77);
    set_rs(0, 5'd5, 1'b0);
    expect_out("rs_unused", 2'b00, 32'h0, 32'h0, 1'b0);
    check_cycle();

    clr_inputs();
    set_stg(0, 1'b1, 5'd8, 1'b0, 32'h0);
    set_stg(1, 1'b1, 5'd8, 1'b1, 32'hCAFE_0008);
    set_rs(0, 5'd8, 1'b1);
    expect_out("young_unready", 2'b00, 32'h0, 32'h0, 1'b1);
    check_cycle();

    clr_inputs();
    set_rs(0, 5'd8, 1'b1);
    expect_out("buf_after_mask", 2'b01, 32'hCAFE_0008, 32'h0, 1'b0);
    check_cycle();

    // retire buffer lives exactly one cycle
    clr_inputs();
    set_stg(1, 1'b1, 5'd3, 1'b1, 32'hDEAD_BEEF);
    expect_out("wb_capture", 2'b00, 32'h0, 32'h0, 1'b0);
    check_cycle();

    clr_inputs();
    set_rs(0, 5'd3, 1'b1);
    expect_out("buf_fwd", 2'b01, 32'hDEAD_BEEF, 32'h0, 1'b0);
    check_cycle();

    clr_inputs();
    set_rs(0, 5'd3, 1'b1);
    expect_out("buf_expired", 2'b00, 32'h0, 32'h0, 1'b0);
    check_cycle();

    // scoreboard
    clr_inputs();
    bus.sb_set = 1'b1; bus.sb_set_rd = 5'd9;
    set_rs(0, 5'd9, 1'b1);
    expect_out("sb_set_cycle", 2'b00, 32'h0, 32'h0, 1'b0);
    check_cycle();

    clr_inputs();
    set_rs(0, 5'd9, 1'b1);
    expect_out("sb_pending", 2'b00, 32'h0, 32'h0, 1'b1);
    check_cycle();

    set_stg(0, 1'b1, 5'd9, 1'b1, 32'h99);
    expect_out("sb_stage_covers", 2'b01, 32'h99, 32'h0, 1'b0);
    check_cycle();

    clr_inputs();
    set_rs(0, 5'd9, 1'b1);
    bus.sb_clr = 1'b1; bus.sb_clr_rd = 5'd9;
    expect_out("sb_clr_cycle", 2'b00, 32'h0, 32'h0, 1'b1);
    check_cycle();

    clr_inputs();
    set_rs(0, 5'd9, 1'b1);
    expect_out("sb_cleared", 2'b00, 32'h0, 32'h0, 1'b0);
    check_cycle();

    clr_inputs();
    bus.sb_set = 1'b1; bus.sb_set_rd = 5'd9;
    bus.sb_clr = 1'b1; bus.sb_clr_rd = 5'd9;
    expect_out("sb_set_clr", 2'b00, 32'h0, 32'h0, 1'b0);
    check_cycle();

    clr_inputs();
    set_rs(0, 5'd9, 1'b1);
    expect_out("sb_set_wins", 2'b00, 32'h0, 32'h0, 1'b1);
    check_cycle();

    clr_inputs();
    bus.sb_clr = 1'b1; bus.sb_clr_rd = 5'd9;
    set_rs(1, 5'd9, 1'b1);
    expect_out("sb_src1_pending", 2'b00, 32'h0, 32'h0, 1'b1);
    check_cycle();

    clr_inputs();
    bus.sb_clr = 1'b1; bus.sb_clr_rd = 5'd12;
    set_rs(1, 5'd9, 1'b1);
    expect_out("sb_src1_clear", 2'b00, 32'h0, 32'h0, 1'b0);
    check_cycle();

    // asynchronous reset with pending entry and non-zero counter
    clr_inputs();
    bus.sb_set = 1'b1; bus.sb_set_rd = 5'd4;
    expect_out("sb_set_r4", 2'b00, 32'h0, 32'h0, 1'b0);
    check_cycle();

    for (int k = 0; k < 4; k++) begin
      clr_inputs();
      set_rs(0, 5'd4, 1'b1);
      expect_out("r4_stall", 2'b00, 32'h0, 32'h0, 1'b1);
      check_cycle();
    end

    clr_inputs();
    set_rs(0, 5'd4, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    exp_cnt = '0;
    tests++;
    assert (bus.stall_cnt === 4'd0) else begin
      fails++; $error("FAIL async_rst_cnt got %0d expected 0", bus.stall_cnt);
    end
    expect_out("in_reset", 2'b00, 32'h0, 32'h0, 1'b0);
    check_cycle();
    rst = 1'b0;

    clr_inputs();
    set_rs(0, 5'd4, 1'b1);
    expect_out("post_reset", 2'b00, 32'h0, 32'h0, 1'b0);
    check_cycle();

    // counter saturation
    clr_inputs();
    bus.sb_set = 1'b1; bus.sb_set_rd = 5'd4;
    expect_out("sat_set", 2'b00, 32'h0, 32'h0, 1'b0);
    check_cycle();

    for (int k = 0; k < 17; k++) begin
      clr_inputs();
      set_rs(0, 5'd4, 1'b1);
      expect_out("sat_stall", 2'b00, 32'h0, 32'h0, 1'b1);
      check_cycle();
    end

    clr_inputs();
    expect_out("sat_hold", 2'b00, 32'h0, 32'h0, 1'b0);
    check_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
